free_list_tracker: RTL and testbench
====================================

# free_list_tracker

Tracks the allocation state of every address in the near-memory region and hands out free addresses on request. Sits directly downstream of the memory controller: it consumes the controller's `used_address`, `freed`, `freed_address` and `read_or_write` stream, keeps a per-address occupancy bitmap, and serves a next-fit allocator port to thread-spawn logic.

## Interface
- `ADDR_W`, 9, address width; the bitmap holds 2^ADDR_W entries.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `use_valid`  in  1  `used_address` / `read_or_write` are valid this cycle.
- `used_address`  in  ADDR_W  address touched by the controller.
- `read_or_write`  in  1  0 = READ, 1 = WRITE; only WRITE marks an address used.
- `freed`  in  1  `freed_address` is released this cycle.
- `freed_address`  in  ADDR_W  address being released.
- `alloc_req`  in  1  level request for a free address; hold until `alloc_gnt`.
- `alloc_gnt`  out  1  one-cycle grant pulse.
- `alloc_addr`  out  ADDR_W  granted address; valid only while `alloc_gnt`=1.
- `used_count`  out  ADDR_W+1  number of set bitmap entries.
- `full`  out  1  `used_count` == 2^ADDR_W.
- `empty`  out  1  `used_count` == 0.
- `err_double_use`  out  1  one-cycle pulse: WRITE to an already-used address.
- `err_double_free`  out  1  one-cycle pulse: free of an already-free address.

## Operation
- **Bitmap:** 2^ADDR_W bits, 1 = used.
- **Same-cycle update order:** free clears, then use-WRITE sets, then allocator reservation sets. A free and a WRITE to the same address in one cycle therefore leave that address used.
- **used_count:** adds the number of 0→1 transitions this cycle and subtracts the number of 1→0 transitions. Net change per cycle ranges from -1 to +2. It never wraps.
- **Allocator FSM states:**
  - IDLE: if `alloc_req` and not `full`, go to SCAN; otherwise stay.
  - SCAN: examine `bitmap[scan_ptr]` (registered value), one entry per cycle.
    - If the entry is 0 and there is no WRITE to `scan_ptr` this cycle: set the bit, latch `alloc_addr`=`scan_ptr`, set `scan_ptr`+1 (mod 2^ADDR_W), go to GRANT.
    - Otherwise: `scan_ptr`+1 and stay in SCAN.
    - If `alloc_req` drops or `full` asserts: go to IDLE with no grant.
  - GRANT: drive `alloc_gnt`=1 for exactly one cycle, then go to IDLE. The grant completes even if `alloc_req` dropped in this cycle; the address stays used.
- **scan_ptr:** persists across grants (next-fit) and wraps from 2^ADDR_W-1 to 0.
- **READ:** a READ with `use_valid` does not change the bitmap.
- **Reset:** bitmap all 0, `used_count`=0, `scan_ptr`=0, FSM IDLE. All outputs 0 except `empty`=1. Reset mid-SCAN or mid-GRANT aborts the operation with no grant.

## Timing
- Bitmap, count, `full`/`empty` and error outputs are registered, visible the cycle after the event.
- **Allocation latency:**
  - Request seen at cycle 0 with a free entry at `scan_ptr` gives `alloc_gnt` at cycle 2.
  - Each additional used entry skipped adds one cycle.
  - Worst case is 2^ADDR_W+1 cycles.
- Back-to-back grants are at least 3 cycles apart (IDLE→SCAN→GRANT).
- Error pulses are one cycle wide, one cycle after the offending input.

## Configuration
- `FREE_LIST_ERR_CHECK_EN` defined:
  - `err_double_use` and `err_double_free` are generated as described above.
  - A READ of a free address also pulses `err_double_use`.
- Not defined:
  - Both error outputs are tied to 0.
  - The bitmap and count behaviour is unchanged: a double WRITE or double free is a silent no-op on the count.

## Test plan
- **Reset/empty:** assert `rst` 2 cycles → `used_count`=0, `empty`=1, `full`=0, `alloc_gnt`=0.
- **Use/free:** WRITE to 5, then `freed`=1 with `freed_address`=5 → `used_count` goes 0→1→0. A second free of 5 gives one `err_double_free` pulse (macro on) or none (macro off).
- **Next-fit skip:** WRITE 0,1,2, then hold `alloc_req` → `alloc_gnt` with `alloc_addr`=3, 5 cycles after the request. A second request is granted 4.
- **Full, ADDR_W=3:** 8 WRITEs → `full`=1. Hold `alloc_req` 20 cycles → no grant. Free address 6 → grant with `alloc_addr`=6.
- **Collision:** scanner at 7 with bit 7 free while WRITE to 7 in the same cycle → 7 is skipped, grant is 8, `used_count` +2, no error.
- **Reset mid-scan:** assert `rst` while in SCAN → no `alloc_gnt` follows. After reset a request is granted `alloc_addr`=0.

Source files
------------

// File: rtl/free_list_tracker.sv
// Per-address occupancy bitmap with a next-fit allocator for thread-spawn logic.
// Define FREE_LIST_ERR_CHECK_EN to generate the err_double_use / err_double_free pulses.
module free_list_tracker #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              use_valid,
  input  logic [ADDR_W-1:0] used_address,
  input  logic              read_or_write,
  input  logic              freed,
  input  logic [ADDR_W-1:0] freed_address,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [ADDR_W-1:0] alloc_addr,
  output logic [ADDR_W:0]   used_count,
  output logic              full,
  output logic              empty,
  output logic              err_double_use,
  output logic              err_double_free
);

  localparam int unsigned     Depth    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PtrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StScan, StGrant} state_e;

  logic [Depth-1:0]  bitmap_q, bitmap_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [ADDR_W-1:0] scan_ptr_q, scan_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              gnt_q, gnt_d;
  state_e            state_q, state_d;

  logic wr_en;
  logic scan_bit;
  logic scan_clash;
  logic inc_wr;
  logic dec_free;
  logic reserve;

  always_comb begin
    wr_en      = use_valid & read_or_write;
    scan_bit   = bitmap_q[scan_ptr_q];
    scan_clash = wr_en & (used_address == scan_ptr_q);
    inc_wr     = wr_en & ~bitmap_q[used_address];
    // A free cancelled by a same-cycle WRITE to the same address leaves it used.
    dec_free   = freed & bitmap_q[freed_address] &
                 ~(wr_en & (used_address == freed_address));
  end

  always_comb begin
    state_d    = state_q;
    scan_ptr_d = scan_ptr_q;
    addr_d     = addr_q;
    reserve    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (alloc_req && !full_q) state_d = StScan;
      end
      StScan: begin
        if (!alloc_req || full_q) begin
          state_d = StIdle;
        end else begin
          scan_ptr_d = scan_ptr_q + PtrOne;
          // Never hand out an entry the controller is writing this very cycle.
          if (!scan_bit && !scan_clash) begin
            reserve = 1'b1;
            addr_d  = scan_ptr_q;
            state_d = StGrant;
          end
        end
      end
      StGrant: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    gnt_d = (state_d == StGrant);
  end

  always_comb begin
    bitmap_d = bitmap_q;
    if (freed)   bitmap_d[freed_address] = 1'b0;
    if (wr_en)   bitmap_d[used_address]  = 1'b1;
    if (reserve) bitmap_d[scan_ptr_q]    = 1'b1;
    count_d = count_q + {{ADDR_W{1'b0}}, inc_wr} + {{ADDR_W{1'b0}}, reserve}
            - {{ADDR_W{1'b0}}, dec_free};
    full_d  = (count_d == DepthCnt);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      scan_ptr_q <= '0;
      addr_q     <= '0;
      gnt_q      <= 1'b0;
      state_q    <= StIdle;
    end else begin
      bitmap_q   <= bitmap_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      scan_ptr_q <= scan_ptr_d;
      addr_q     <= addr_d;
      gnt_q      <= gnt_d;
      state_q    <= state_d;
    end
  end

  assign alloc_gnt  = gnt_q;
  assign alloc_addr = addr_q;
  assign used_count = count_q;
  assign full       = full_q;
  assign empty      = empty_q;

`ifdef FREE_LIST_ERR_CHECK_EN
  logic used_after_free;
  logic err_use_q, err_use_d;
  logic err_free_q, err_free_d;

  always_comb begin
    // Errors are judged against the state after this cycle's free is applied.
    used_after_free = bitmap_q[used_address] & ~(freed & (freed_address == used_address));
    err_use_d       = use_valid & (read_or_write ? used_after_free : ~used_after_free);
    err_free_d      = freed & ~bitmap_q[freed_address];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_use_q  <= 1'b0;
      err_free_q <= 1'b0;
    end else begin
      err_use_q  <= err_use_d;
      err_free_q <= err_free_d;
    end
  end

  assign err_double_use  = err_use_q;
  assign err_double_free = err_free_q;
`else
  assign err_double_use  = 1'b0;
  assign err_double_free = 1'b0;
`endif

endmodule

// File: tb/tb_free_list_tracker.sv
// Directed bench for free_list_tracker: vector table for bitmap/count/errors plus
// hand sequences for allocation latency, full, collision and reset-mid-scan.
module tb_free_list_tracker;

`ifdef FREE_LIST_ERR_CHECK_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       use_valid, read_or_write, freed, alloc_req;
  logic [8:0] used_address, freed_address;
  logic       alloc_gnt, full, empty, err_double_use, err_double_free;
  logic [8:0] alloc_addr;
  logic [9:0] used_count;

  logic       s_uv, s_rw, s_fr, s_req;
  logic [2:0] s_ua, s_fa;
  logic       s_gnt, s_full, s_empty, s_edu, s_edf;
  logic [2:0] s_addr;
  logic [3:0] s_count;

  free_list_tracker #(.ADDR_W(9)) dut (
    .clk(clk), .rst(rst), .use_valid(use_valid), .used_address(used_address),
    .read_or_write(read_or_write), .freed(freed), .freed_address(freed_address),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_addr(alloc_addr),
    .used_count(used_count), .full(full), .empty(empty),
    .err_double_use(err_double_use), .err_double_free(err_double_free)
  );

  free_list_tracker #(.ADDR_W(3)) dut_small (
    .clk(clk), .rst(rst), .use_valid(s_uv), .used_address(s_ua),
    .read_or_write(s_rw), .freed(s_fr), .freed_address(s_fa),
    .alloc_req(s_req), .alloc_gnt(s_gnt), .alloc_addr(s_addr),
    .used_count(s_count), .full(s_full), .empty(s_empty),
    .err_double_use(s_edu), .err_double_free(s_edf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic       uv;
    logic [8:0] ua;
    logic       rw;
    logic       fr;
    logic [8:0] fa;
    logic [9:0] cnt;
    logic       emp;
    logic       edu;
    logic       edf;
  } vec_t;

  function automatic vec_t mk(input string n, input logic uv, input logic [8:0] ua,
                              input logic rw, input logic fr, input logic [8:0] fa,
                              input logic [9:0] cnt, input logic emp, input logic edu,
                              input logic edf);
    vec_t v;
    v.name = n; v.uv = uv; v.ua = ua; v.rw = rw; v.fr = fr; v.fa = fa;
    v.cnt = cnt; v.emp = emp; v.edu = edu; v.edf = edf;
    return v;
  endfunction

  task automatic wait_gnt(input int budget, output int lat, output logic [8:0] a);
    lat = -1;
    a   = '0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (alloc_gnt === 1'b1) begin
        lat = k;
        a   = alloc_addr;
        break;
      end
    end
  endtask

  task automatic do_write(input logic [8:0] a);
    use_valid = 1'b1; used_address = a; read_or_write = 1'b1;
    @(negedge clk);
    use_valid = 1'b0;
  endtask

  vec_t       vecs[13];
  int         lat;
  logic [8:0] ga;
  logic [9:0] gcnt;
  logic       seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk("w5",      1'b1, 9'd5, 1'b1, 1'b0, 9'd0, 10'd0 + 10'd1, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk("f5",      1'b0, 9'd0, 1'b0, 1'b1, 9'd5, 10'd0, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk("f5_dbl",  1'b0, 9'd0, 1'b0, 1'b1, 9'd5, 10'd0, 1'b1, 1'b0, ErrEn);
    vecs[3]  = mk("r9_free", 1'b1, 9'd9, 1'b0, 1'b0, 9'd0, 10'd0, 1'b1, ErrEn, 1'b0);
    vecs[4]  = mk("w9",      1'b1, 9'd9, 1'b1, 1'b0, 9'd0, 10'd1, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk("w9_dbl",  1'b1, 9'd9, 1'b1, 1'b0, 9'd0, 10'd1, 1'b0, ErrEn, 1'b0);
    vecs[6]  = mk("w9f9",    1'b1, 9'd9, 1'b1, 1'b1, 9'd9, 10'd1, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk("r9_used", 1'b1, 9'd9, 1'b0, 1'b0, 9'd0, 10'd1, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk("f9",      1'b0, 9'd0, 1'b0, 1'b1, 9'd9, 10'd0, 1'b1, 1'b0, 1'b0);
    vecs[9]  = mk("idle",    1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 10'd0, 1'b1, 1'b0, 1'b0);
    vecs[10] = mk("w0",      1'b1, 9'd0, 1'b1, 1'b0, 9'd0, 10'd1, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk("w1",      1'b1, 9'd1, 1'b1, 1'b0, 9'd0, 10'd2, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk("w2",      1'b1, 9'd2, 1'b1, 1'b0, 9'd0, 10'd3, 1'b0, 1'b0, 1'b0);

    rst = 1'b1;
    use_valid = 1'b0; used_address = '0; read_or_write = 1'b0;
    freed = 1'b0; freed_address = '0; alloc_req = 1'b0;
    s_uv = 1'b0; s_ua = '0; s_rw = 1'b0; s_fr = 1'b0; s_fa = '0; s_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", used_count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_gnt", alloc_gnt, 0);
    chk("rst_addr", alloc_addr, 0);
    chk("rst_edu", err_double_use, 0);
    chk("rst_edf", err_double_free, 0);
    chk("rst_small_empty", s_empty, 1);
    rst = 1'b0;

    // Small instance: fill all 8 entries, then allocation only after a free.
    for (int a = 0; a < 8; a++) begin
      s_uv = 1'b1; s_rw = 1'b1; s_ua = 3'(a);
      @(negedge clk);
    end
    s_uv = 1'b0;
    chk("small_count_full", s_count, 8);
    chk("small_full", s_full, 1);
    s_req = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (s_gnt) seen = 1'b1;
    end
    chk("small_full_no_gnt", seen, 0);
    s_fr = 1'b1; s_fa = 3'd6;
    @(negedge clk);
    s_fr = 1'b0;
    chk("small_after_free_full", s_full, 0);
    chk("small_after_free_count", s_count, 7);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (s_gnt) begin
        lat = k;
        ga = {6'd0, s_addr};
        break;
      end
    end
    s_req = 1'b0;
    chk("small_gnt_seen", (lat > 0), 1);
    chk("small_gnt_addr", ga, 6);
    chk("small_refull", s_full, 1);

    for (int i = 0; i < 13; i++) begin
      use_valid = vecs[i].uv; used_address = vecs[i].ua; read_or_write = vecs[i].rw;
      freed = vecs[i].fr; freed_address = vecs[i].fa;
      @(negedge clk);
      chk({vecs[i].name, "_count"}, used_count, vecs[i].cnt);
      chk({vecs[i].name, "_empty"}, empty, vecs[i].emp);
      chk({vecs[i].name, "_edu"}, err_double_use, vecs[i].edu);
      chk({vecs[i].name, "_edf"}, err_double_free, vecs[i].edf);
      chk({vecs[i].name, "_gnt"}, alloc_gnt, 0);
    end
    use_valid = 1'b0; freed = 1'b0;

    // Next-fit: 0..2 used, so scanning 0,1,2 before granting 3.
    alloc_req = 1'b1;
    wait_gnt(20, lat, ga);
    alloc_req = 1'b0;
    chk("nf1_latency", lat, 5);
    chk("nf1_addr", ga, 3);
    chk("nf1_count", used_count, 4);
    @(negedge clk);
    chk("nf1_gnt_width", alloc_gnt, 0);
    alloc_req = 1'b1;
    wait_gnt(20, lat, ga);
    alloc_req = 1'b0;
    chk("nf2_latency", lat, 2);
    chk("nf2_addr", ga, 4);

    do_write(9'd5);
    do_write(9'd6);
    chk("pre_collision_count", used_count, 7);

    // Collision: WRITE to 7 lands in the cycle the scanner examines 7.
    alloc_req = 1'b1;
    lat = -1; seen = 1'b0; gcnt = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (err_double_use) seen = 1'b1;
      if (alloc_gnt) begin
        lat = k; ga = alloc_addr; gcnt = used_count;
        break;
      end
      if (k == 3) begin
        use_valid = 1'b1; used_address = 9'd7; read_or_write = 1'b1;
      end else begin
        use_valid = 1'b0;
      end
    end
    alloc_req = 1'b0; use_valid = 1'b0;
    chk("coll_latency", lat, 5);
    chk("coll_addr", ga, 8);
    chk("coll_count", gcnt, 9);
    chk("coll_no_err", seen, 0);

    // Reset while scanning with a free entry at scan_ptr: that grant must never appear.
    @(negedge clk);
    alloc_req = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (alloc_gnt) begin
        lat = k; ga = alloc_addr; gcnt = used_count;
        break;
      end
      if (k == 2) begin
        chk("midscan_rst_count", used_count, 0);
        chk("midscan_rst_empty", empty, 1);
        rst = 1'b0;
      end
    end
    alloc_req = 1'b0;
    chk("post_rst_latency", lat, 4);
    chk("post_rst_addr", ga, 0);
    chk("post_rst_count", gcnt, 1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
